// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive controller: state encoding,
// default frame geometry and the even-parity helper used when the
// UART_RX_PARITY_EN build option is enabled.
package uart_rx_pkg;

   localparam int DEF_OVERSAMPLE = 16;
   localparam int DEF_DATA_BITS  = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_HIGH = 3'd5
   } rx_state_t;

   // Even parity over up to 9 data bits; narrower frames are zero-extended.
   function automatic logic even_parity(input logic [8:0] i_data);
      return ^i_data;
   endfunction

endpackage

// File: rtl/uart_rx_controller_if.sv
// Bundles the receiver line, strobe, byte handshake and status pulses.
// master = receiver side, slave = line driver / byte consumer side.
interface uart_rx_controller_if #(
   parameter int DATA_BITS = uart_rx_pkg::DEF_DATA_BITS
);
   logic                 sample_en;
   logic                 serial_in;
   logic                 rx_ack;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 busy;
   logic                 frame_error;
   logic                 overrun;
   logic                 parity_error;

   modport master (
      input  sample_en, serial_in, rx_ack,
      output rx_data, rx_valid, busy, frame_error, overrun, parity_error
   );

   modport slave (
      output sample_en, serial_in, rx_ack,
      input  rx_data, rx_valid, busy, frame_error, overrun, parity_error
   );
endinterface

// File: rtl/uart_rx_bit_timer.sv
// Oversample tick counter. Advances only on the enable strobe, clears on
// request and flags the mid-bit and end-of-bit tick positions.
module uart_rx_bit_timer #(
   parameter int OVERSAMPLE = uart_rx_pkg::DEF_OVERSAMPLE
) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   input  logic i_clear,
   output logic o_mid_tick,
   output logic o_end_tick
);
   localparam int TW = $clog2(OVERSAMPLE);

   logic [TW-1:0] r_tick;

   // Tick counter; wraps naturally because OVERSAMPLE is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tick <= '0;
      end else if (i_en) begin
         r_tick <= i_clear ? '0 : r_tick + TW'(1);
      end
   end

   assign o_mid_tick = (r_tick == TW'(OVERSAMPLE/2 - 1));
   assign o_end_tick = (r_tick == TW'(OVERSAMPLE - 1));

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive sequencer: start-bit detection, mid-bit sampling of an
// LSB-first frame, stop-bit check and a valid/ack holding register.
// Build option UART_RX_PARITY_EN inserts an even-parity bit before stop.
module uart_rx_controller
   import uart_rx_pkg::*;
#(
   parameter int OVERSAMPLE = DEF_OVERSAMPLE,
   parameter int DATA_BITS  = DEF_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   uart_rx_controller_if.master bus
);
   localparam int             BW       = $clog2(DATA_BITS + 1);
   localparam logic [BW-1:0]  LAST_BIT = BW'(DATA_BITS - 1);

   rx_state_t            r_state, w_state_next;
   logic                 r_sync1, r_line_s, r_line_q;
   logic [BW-1:0]        r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift, r_rx_data;
   logic                 r_rx_valid, r_frame_error, r_overrun;
   logic                 w_mid_tick, w_end_tick, w_tick_clear;
   logic                 w_shift_en, w_bit_clear, w_bit_inc;
   logic                 w_good_frame, w_frame_err;
`ifdef UART_RX_PARITY_EN
   logic                 r_par_bit, r_parity_error;
   logic                 w_par_sample, w_parity_err, w_par_calc;
   logic [8:0]           w_par_in;
`endif

   uart_rx_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_bit_timer (
      .clk        (clk),
      .reset      (reset),
      .i_en       (bus.sample_en),
      .i_clear    (w_tick_clear),
      .o_mid_tick (w_mid_tick),
      .o_end_tick (w_end_tick)
   );

   // Two-flop synchroniser plus a strobe-rate copy for edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1  <= 1'b1;
         r_line_s <= 1'b1;
         r_line_q <= 1'b1;
      end else begin
         r_sync1  <= bus.serial_in;
         r_line_s <= r_sync1;
         if (bus.sample_en) r_line_q <= r_line_s;
      end
   end

`ifdef UART_RX_PARITY_EN
   // Expected parity of the assembled data word.
   always_comb begin
      w_par_in                = '0;
      w_par_in[DATA_BITS-1:0] = r_shift;
      w_par_calc              = even_parity(w_par_in);
   end
`endif

   // Next-state and per-strobe actions; nothing happens between strobes.
   always_comb begin
      w_state_next = r_state;
      w_tick_clear = 1'b0;
      w_shift_en   = 1'b0;
      w_bit_clear  = 1'b0;
      w_bit_inc    = 1'b0;
      w_good_frame = 1'b0;
      w_frame_err  = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_sample = 1'b0;
      w_parity_err = 1'b0;
`endif
      if (bus.sample_en) begin
         case (r_state)
            IDLE: begin
               w_tick_clear = 1'b1;
               if (r_line_q && !r_line_s) w_state_next = START;
            end
            START: begin
               if (w_mid_tick) begin
                  w_tick_clear = 1'b1;
                  w_state_next = r_line_s ? IDLE : DATA;
               end
            end
            DATA: begin
               if (w_end_tick) begin
                  w_shift_en = 1'b1;
                  if (r_bit_cnt == LAST_BIT) begin
                     w_bit_clear = 1'b1;
`ifdef UART_RX_PARITY_EN
                     w_state_next = PARITY;
`else
                     w_state_next = STOP;
`endif
                  end else begin
                     w_bit_inc = 1'b1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (w_end_tick) begin
                  w_par_sample = 1'b1;
                  w_state_next = STOP;
               end
            end
`endif
            STOP: begin
               if (w_end_tick) begin
                  w_state_next = IDLE;
                  // A low stop bit wins over any parity complaint.
                  if (!r_line_s) begin
                     w_frame_err  = 1'b1;
                     w_state_next = WAIT_HIGH;
                  end
`ifdef UART_RX_PARITY_EN
                  else if (r_par_bit != w_par_calc) w_parity_err = 1'b1;
`endif
                  else w_good_frame = 1'b1;
               end
            end
            WAIT_HIGH: begin
               w_tick_clear = 1'b1;
               if (r_line_s) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
         endcase
      end
   end

   // FSM state, bit counter and LSB-first shift register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_bit_cnt <= '0;
         r_shift   <= '0;
`ifdef UART_RX_PARITY_EN
         r_par_bit <= 1'b0;
`endif
      end else if (bus.sample_en) begin
         r_state <= w_state_next;
         if (w_bit_clear)    r_bit_cnt <= '0;
         else if (w_bit_inc) r_bit_cnt <= r_bit_cnt + BW'(1);
         if (w_shift_en)     r_shift <= {r_line_s, r_shift[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
         if (w_par_sample)   r_par_bit <= r_line_s;
`endif
      end
   end

   // Holding register, handshake and one-clock status pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rx_data     <= '0;
         r_rx_valid    <= 1'b0;
         r_frame_error <= 1'b0;
         r_overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_error <= 1'b0;
`endif
      end else begin
         r_frame_error <= w_frame_err;
         r_overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_error <= w_parity_err;
`endif
         if (w_good_frame && (!r_rx_valid || bus.rx_ack)) begin
            r_rx_data  <= r_shift;
            r_rx_valid <= 1'b1;
         end else begin
            if (w_good_frame) r_overrun  <= 1'b1;
            if (bus.rx_ack)   r_rx_valid <= 1'b0;
         end
      end
   end

   assign bus.rx_data     = r_rx_data;
   assign bus.rx_valid    = r_rx_valid;
   assign bus.busy        = (r_state != IDLE);
   assign bus.frame_error = r_frame_error;
   assign bus.overrun     = r_overrun;
`ifdef UART_RX_PARITY_EN
   assign bus.parity_error = r_parity_error;
`else
   assign bus.parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller (OVERSAMPLE=16, DATA_BITS=8,
// sample_en every 4th clk). Honours UART_RX_PARITY_EN when defined.
module tb_uart_rx_controller;
   localparam int OS = 16;
   localparam int DB = 8;
`ifdef UART_RX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   // Strobes from the strobe edge that follows the line fall to the stop sample:
   // 1 detection + 8 start + 16 per data/parity bit + 16 stop.
   localparam int GAP = 1 + OS/2 + OS*(DB + PB) + OS;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [1:0] div = 2'd0;

   int   n_cmp = 0;
   int   n_err = 0;
   int   strobe_cnt = 0;
   int   fall_strobe = 0;
   int   rise_strobe = 0;
   int   n_rise = 0, n_ferr = 0, n_ovr = 0, n_perr = 0;
   int   b_rise, b_ferr, b_ovr, b_perr;
   time  last_strobe_t = 0;
   time  rise_dt = 0;
   logic valid_prev = 1'b0, busy_prev = 1'b0;
   logic busy_at_rise = 1'b0, busy_before_rise = 1'b0;

   uart_rx_controller_if #(.DATA_BITS(DB)) ifc ();

   uart_rx_controller #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   // Oversample strobe: one clk in four.
   initial begin
      ifc.sample_en = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         div = div + 2'd1;
         ifc.sample_en = (div == 2'd0);
      end
   end

   // Strobe bookkeeping.
   always @(posedge clk) begin
      if (ifc.sample_en) begin
         strobe_cnt    <= strobe_cnt + 1;
         last_strobe_t <= $time;
      end
   end

   // Output monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (ifc.frame_error)  n_ferr <= n_ferr + 1;
      if (ifc.overrun)      n_ovr  <= n_ovr + 1;
      if (ifc.parity_error) n_perr <= n_perr + 1;
      if (ifc.rx_valid && !valid_prev) begin
         n_rise           <= n_rise + 1;
         rise_strobe      <= strobe_cnt;
         rise_dt          <= $time - last_strobe_t;
         busy_at_rise     <= ifc.busy;
         busy_before_rise <= busy_prev;
      end
      valid_prev <= ifc.rx_valid;
      busy_prev  <= ifc.busy;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_strobes(input int n);
      repeat (n) @(posedge clk iff ifc.sample_en);
      #1;
   endtask

   task automatic snap();
      b_rise = n_rise; b_ferr = n_ferr; b_ovr = n_ovr; b_perr = n_perr;
   endtask

   task automatic do_ack();
      @(posedge clk); #1 ifc.rx_ack = 1'b1;
      @(posedge clk); #1 ifc.rx_ack = 1'b0;
      wait_strobes(1);
   endtask

   task automatic send_frame(input logic [7:0] data, input logic par_bit,
                             input logic stop_bit, input int hold_low);
      fall_strobe   = strobe_cnt;
      ifc.serial_in = 1'b0;
      wait_strobes(OS);
      for (int i = 0; i < DB; i++) begin
         ifc.serial_in = data[i];
         wait_strobes(OS);
      end
`ifdef UART_RX_PARITY_EN
      ifc.serial_in = par_bit;
      wait_strobes(OS);
`endif
      ifc.serial_in = stop_bit;
      wait_strobes(OS);
      if (hold_low > 0) begin
         ifc.serial_in = 1'b0;
         wait_strobes(hold_low);
      end
      ifc.serial_in = 1'b1;
      $display("frame 0x%02h par=%0d stop=%0d hold_low=%0d sent", data, par_bit, stop_bit, hold_low);
   endtask

   initial begin
      ifc.serial_in = 1'b1;
      ifc.rx_ack    = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #2;
      check_val("rst_rx_valid", 32'(ifc.rx_valid), 32'd0);
      check_val("rst_rx_data", 32'(ifc.rx_data), 32'd0);
      check_val("rst_busy", 32'(ifc.busy), 32'd0);
      check_val("rst_frame_error", 32'(ifc.frame_error), 32'd0);
      check_val("rst_overrun", 32'(ifc.overrun), 32'd0);
      check_val("rst_parity_error", 32'(ifc.parity_error), 32'd0);
      reset = 1'b1;
      wait_strobes(4);

      // 0xA5 good frame with latency check
      snap();
      send_frame(8'hA5, ^8'hA5, 1'b1, 0);
      wait_strobes(2);
      check_val("a5_data", 32'(ifc.rx_data), 32'hA5);
      check_val("a5_valid", 32'(ifc.rx_valid), 32'd1);
      check_val("a5_rise_strobe", 32'(rise_strobe - fall_strobe), 32'(GAP));
      check_val("a5_rise_one_clk", 32'(rise_dt), 32'd5);
      check_val("a5_busy_at_rise", 32'(busy_at_rise), 32'd0);
      check_val("a5_busy_before_rise", 32'(busy_before_rise), 32'd1);
      check_val("a5_rises", 32'(n_rise - b_rise), 32'd1);
      check_val("a5_ferr", 32'(n_ferr - b_ferr), 32'd0);
      check_val("a5_ovr", 32'(n_ovr - b_ovr), 32'd0);
      do_ack();
      check_val("ack_clears_valid", 32'(ifc.rx_valid), 32'd0);
      do_ack();
      check_val("ack_when_empty", 32'(ifc.rx_valid), 32'd0);

      // False start: low for 5 strobes, START aborts on its 8th strobe
      snap();
      ifc.serial_in = 1'b0;
      wait_strobes(5);
      check_val("fs_busy_mid", 32'(ifc.busy), 32'd1);
      ifc.serial_in = 1'b1;
      wait_strobes(3);
      check_val("fs_busy_last", 32'(ifc.busy), 32'd1);
      wait_strobes(1);
      check_val("fs_busy_end", 32'(ifc.busy), 32'd0);
      wait_strobes(20);
      check_val("fs_rises", 32'(n_rise - b_rise), 32'd0);
      check_val("fs_ferr", 32'(n_ferr - b_ferr), 32'd0);
      check_val("fs_ovr", 32'(n_ovr - b_ovr), 32'd0);
      $display("false start applied");

      // 0x3C with low stop bit, line held low, then 0x81
      snap();
      send_frame(8'h3C, ^8'h3C, 1'b0, 40);
      check_val("fe_busy_wait_high", 32'(ifc.busy), 32'd1);
      check_val("fe_pulses", 32'(n_ferr - b_ferr), 32'd1);
      check_val("fe_valid", 32'(ifc.rx_valid), 32'd0);
      wait_strobes(1);
      check_val("fe_busy_released", 32'(ifc.busy), 32'd0);
      wait_strobes(16);
      send_frame(8'h81, ^8'h81, 1'b1, 0);
      wait_strobes(2);
      check_val("fe_next_data", 32'(ifc.rx_data), 32'h81);
      check_val("fe_next_rises", 32'(n_rise - b_rise), 32'd1);
      check_val("fe_total_ferr", 32'(n_ferr - b_ferr), 32'd1);
      do_ack();

      // Back-to-back 0x3C, 0xC3 without ack: overrun
      snap();
      send_frame(8'h3C, ^8'h3C, 1'b1, 0);
      send_frame(8'hC3, ^8'hC3, 1'b1, 0);
      wait_strobes(2);
      check_val("ovr_data_kept", 32'(ifc.rx_data), 32'h3C);
      check_val("ovr_valid", 32'(ifc.rx_valid), 32'd1);
      check_val("ovr_pulses", 32'(n_ovr - b_ovr), 32'd1);
      check_val("ovr_ferr", 32'(n_ferr - b_ferr), 32'd0);
      do_ack();

      // Same pair with ack in the 0xC3 delivery cycle
      snap();
      send_frame(8'h3C, ^8'h3C, 1'b1, 0);
      fork
         send_frame(8'hC3, ^8'hC3, 1'b1, 0);
         begin
            wait_strobes(GAP - 1);
            repeat (3) @(posedge clk);
            #1 ifc.rx_ack = 1'b1;
            @(posedge clk);
            #1 ifc.rx_ack = 1'b0;
         end
      join
      wait_strobes(2);
      check_val("ackd_data", 32'(ifc.rx_data), 32'hC3);
      check_val("ackd_valid", 32'(ifc.rx_valid), 32'd1);
      check_val("ackd_ovr", 32'(n_ovr - b_ovr), 32'd0);
      check_val("ackd_rises", 32'(n_rise - b_rise), 32'd1);

      // Asynchronous reset during data bit 4 of 0xFF, byte 0xC3 still held
      snap();
      fork
         send_frame(8'hFF, ^8'hFF, 1'b1, 0);
         begin
            wait_strobes(84);
            #3;
            check_val("ar_busy_before", 32'(ifc.busy), 32'd1);
            reset = 1'b0;
            #1;
            check_val("ar_valid", 32'(ifc.rx_valid), 32'd0);
            check_val("ar_data", 32'(ifc.rx_data), 32'd0);
            check_val("ar_busy", 32'(ifc.busy), 32'd0);
            @(posedge clk);
            @(posedge clk);
            #3 reset = 1'b1;
         end
      join
      wait_strobes(4);
      check_val("ar_no_rise", 32'(n_rise - b_rise), 32'd0);
      check_val("ar_no_ferr", 32'(n_ferr - b_ferr), 32'd0);
      send_frame(8'h55, ^8'h55, 1'b1, 0);
      wait_strobes(2);
      check_val("ar_next_data", 32'(ifc.rx_data), 32'h55);
      check_val("ar_next_rises", 32'(n_rise - b_rise), 32'd1);
      do_ack();

`ifdef UART_RX_PARITY_EN
      // Parity good / bad
      snap();
      send_frame(8'h0F, 1'b0, 1'b1, 0);
      wait_strobes(2);
      check_val("par_ok_data", 32'(ifc.rx_data), 32'h0F);
      check_val("par_ok_perr", 32'(n_perr - b_perr), 32'd0);
      do_ack();
      snap();
      send_frame(8'h0F, 1'b1, 1'b1, 0);
      wait_strobes(2);
      check_val("par_bad_perr", 32'(n_perr - b_perr), 32'd1);
      check_val("par_bad_valid", 32'(ifc.rx_valid), 32'd0);
      check_val("par_bad_rises", 32'(n_rise - b_rise), 32'd0);
`else
      check_val("parity_never", 32'(n_perr), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
